// File: rtl/router_pkt_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : router_pkt_tx_pkg                                                |
// | Purpose : Shared constants, header field layout, transmitter FSM encoding  |
// |           and small helpers for the router packet transmitter.             |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package router_pkt_tx_pkg;

  // Destination port 3 does not exist on the 1x3 router.
  localparam logic [1:0] ADDR_ILLEGAL = 2'd3;

  // Header byte layout: {len[5:0], addr[1:0]}.
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_LEN_MSB  = 7;

  // Largest payload the 6-bit header length field can describe.
  localparam int MAX_LEN = 63;
  localparam int IDX_W   = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_HEADER  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_PARITY  = 3'd4,
    ST_ERRWIN  = 3'd5
  } tx_state_e;

  function automatic logic [7:0] make_header(input logic [IDX_W-1:0] len,
                                             input logic [1:0]       addr);
    logic [7:0] h;
    h = '0;
    h[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
    h[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
    return h;
  endfunction

  function automatic logic start_legal(input logic [1:0]       addr,
                                       input logic [IDX_W-1:0] len);
    return (addr != ADDR_ILLEGAL) && (len != '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_pkt_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : router_pkt_tx_if                                               |
// | Purpose   : Bundles the host request/payload side and the router byte side |
// |             of the packet transmitter.                                     |
// | Modports  : master - the transmitter (drives data_out/pkt_valid/status)    |
// |             slave  - the environment (host + router)                       |
// | Signals   : start/addr/len/corrupt_parity  packet request                  |
// |             pl_data/pl_valid/pl_ready      payload stream                  |
// |             busy/error                     router flow control / status    |
// |             data_out/pkt_valid             router input bytes              |
// |             tx_idle/reject/done/err_flag/err_count  transmitter status     |
// | Rev       : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface router_pkt_tx_if;
  import router_pkt_tx_pkg::*;

  logic             start;
  logic [1:0]       addr;
  logic [IDX_W-1:0] len;
  logic             corrupt_parity;
  logic [7:0]       pl_data;
  logic             pl_valid;
  logic             pl_ready;
  logic             busy;
  logic             error;
  logic [7:0]       data_out;
  logic             pkt_valid;
  logic             tx_idle;
  logic             reject;
  logic             done;
  logic             err_flag;
  logic [7:0]       err_count;

  modport master (
    input  start, addr, len, corrupt_parity, pl_data, pl_valid, busy, error,
    output pl_ready, data_out, pkt_valid, tx_idle, reject, done, err_flag, err_count
  );

  modport slave (
    output start, addr, len, corrupt_parity, pl_data, pl_valid, busy, error,
    input  pl_ready, data_out, pkt_valid, tx_idle, reject, done, err_flag, err_count
  );

endinterface
`default_nettype wire

// File: rtl/router_pkt_tx_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : router_pkt_tx_buf                                                |
// | Purpose : 64x8 payload buffer, one synchronous write port and one          |
// |           combinational read port. Contents are not reset.                 |
// | Ports   : clock      in   system clock                                     |
// |           wr_en_i    in   write strobe                                     |
// |           wr_idx_i   in   write index                                      |
// |           wr_data_i  in   write byte                                       |
// |           rd_idx_i   in   read index                                       |
// |           rd_data_o  out  byte at rd_idx_i                                 |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module router_pkt_tx_buf
  import router_pkt_tx_pkg::*;
(
  input  logic             clock,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [7:0]       wr_data_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [7:0]       rd_data_o
);

  logic [7:0] mem_q [0:MAX_LEN];

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule
`default_nettype wire

// File: rtl/router_pkt_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : router_pkt_tx                                                    |
// | Purpose : Router input-port traffic source. Buffers a host payload, then   |
// |           sends header {len,addr}, len payload bytes and an XOR parity     |
// |           byte, honouring router busy, then watches router error for       |
// |           ERR_WIN cycles after the parity byte is accepted.                |
// | Ports   : clock   in   system clock                                        |
// |           resetn  in   synchronous active-low reset                        |
// |           tx_if   master modport of router_pkt_tx_if (host + router side)  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module router_pkt_tx
  import router_pkt_tx_pkg::*;
#(
  parameter int ERR_WIN = 4
) (
  input  logic            clock,
  input  logic            resetn,
  router_pkt_tx_if.master tx_if
);

  localparam logic [3:0] WIN_LAST = 4'(ERR_WIN - 1);

  tx_state_e        state_q;
  logic [1:0]       addr_q;
  logic [IDX_W-1:0] len_q;
  logic             corrupt_q;
  logic [IDX_W-1:0] wr_idx_q;
  logic [IDX_W-1:0] rd_idx_q;
  logic [7:0]       parity_q;
  logic [3:0]       win_q;

  logic [7:0]       data_out_q;
  logic             pkt_valid_q;
  logic             pl_ready_q;
  logic             reject_q;
  logic             done_q;
  logic             err_flag_q;
  logic [7:0]       err_count_q;

  logic             buf_we_d;
  logic [7:0]       buf_rd_data_d;
  logic [7:0]       hdr_d;
  logic             err_seen_d;

  assign buf_we_d   = (state_q == ST_LOAD) && tx_if.pl_valid && pl_ready_q;
  assign hdr_d      = make_header(len_q, addr_q);
  // Error seen so far including this cycle's sample, so the final window
  // edge both updates err_flag and counts it.
  assign err_seen_d = err_flag_q | tx_if.error;

  router_pkt_tx_buf u_buf (
    .clock     (clock),
    .wr_en_i   (buf_we_d),
    .wr_idx_i  (wr_idx_q),
    .wr_data_i (tx_if.pl_data),
    .rd_idx_i  (rd_idx_q),
    .rd_data_o (buf_rd_data_d)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      corrupt_q   <= 1'b0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      parity_q    <= '0;
      win_q       <= '0;
      data_out_q  <= '0;
      pkt_valid_q <= 1'b0;
      pl_ready_q  <= 1'b0;
      reject_q    <= 1'b0;
      done_q      <= 1'b0;
      err_flag_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      reject_q <= 1'b0;
      done_q   <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (tx_if.start) begin
            if (start_legal(tx_if.addr, tx_if.len)) begin
              addr_q     <= tx_if.addr;
              len_q      <= tx_if.len;
              corrupt_q  <= tx_if.corrupt_parity;
              wr_idx_q   <= '0;
              rd_idx_q   <= '0;
              parity_q   <= '0;
              err_flag_q <= 1'b0;
              pl_ready_q <= 1'b1;
              state_q    <= ST_LOAD;
            end else begin
              reject_q <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          if (buf_we_d) begin
            wr_idx_q <= wr_idx_q + 6'd1;
            if (wr_idx_q == len_q - 6'd1) begin
              // Last payload byte: fold the header into parity as it launches.
              parity_q    <= parity_q ^ tx_if.pl_data ^ hdr_d;
              data_out_q  <= hdr_d;
              pkt_valid_q <= 1'b1;
              pl_ready_q  <= 1'b0;
              state_q     <= ST_HEADER;
            end else begin
              parity_q <= parity_q ^ tx_if.pl_data;
            end
          end
        end

        ST_HEADER: begin
          if (!tx_if.busy) begin
            data_out_q <= buf_rd_data_d;
            rd_idx_q   <= rd_idx_q + 6'd1;
            state_q    <= ST_PAYLOAD;
          end
        end

        ST_PAYLOAD: begin
          // rd_idx_q counts payload bytes already presented; equal to len
          // means the byte on data_out is the last one.
          if (!tx_if.busy) begin
            if (rd_idx_q == len_q) begin
              data_out_q  <= parity_q ^ {7'b0, corrupt_q};
              pkt_valid_q <= 1'b0;
              state_q     <= ST_PARITY;
            end else begin
              data_out_q <= buf_rd_data_d;
              rd_idx_q   <= rd_idx_q + 6'd1;
            end
          end
        end

        ST_PARITY: begin
          if (!tx_if.busy) begin
            win_q   <= '0;
            state_q <= ST_ERRWIN;
          end
        end

        ST_ERRWIN: begin
          err_flag_q <= err_seen_d;
          if (win_q == WIN_LAST) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
            if (err_seen_d && (err_count_q != 8'hFF)) begin
              err_count_q <= err_count_q + 8'd1;
            end
          end else begin
            win_q <= win_q + 4'd1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_if.data_out  = data_out_q;
  assign tx_if.pkt_valid = pkt_valid_q;
  assign tx_if.pl_ready  = pl_ready_q;
  assign tx_if.tx_idle   = (state_q == ST_IDLE);
  assign tx_if.reject    = reject_q;
  assign tx_if.done      = done_q;
  assign tx_if.err_flag  = err_flag_q;
  assign tx_if.err_count = err_count_q;

endmodule
`default_nettype wire
